// File: rtl/dlfloat16_dot_seq.sv
// rtl/dlfloat16_dot_seq.sv - DLFloat16 dot-product sequencer feeding dlfloat16_mac
// Optional overflow drain enabled by defining DLFLOAT_SEQ_OVF_STOP_EN.
module dlfloat16_dot_seq #(
  parameter int MAX_TERMS = 255,
  parameter int MAC_LAT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_last,
  output logic [15:0] mac_a,
  output logic [15:0] mac_b,
  output logic [15:0] mac_d,
  output logic [3:0]  mac_ena,
  input  logic [19:0] mac_c,
  input  logic [4:0]  mac_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [4:0]  out_flags,
  output logic [7:0]  out_count
);

  localparam logic [7:0] MAX_CNT  = 8'(MAX_TERMS);
  localparam logic [2:0] LAT_INIT = 3'(MAC_LAT);

`ifdef DLFLOAT_SEQ_OVF_STOP_EN
  typedef enum logic [2:0] {ACCEPT, ISSUE, WAIT, DONE, DRAIN} state_t;
`else
  typedef enum logic [2:0] {ACCEPT, ISSUE, WAIT, DONE} state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [4:0]  flg_q, flg_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic [2:0]  lat_cnt_q, lat_cnt_d;
  logic [15:0] mac_a_q, mac_a_d, mac_b_q, mac_b_d, mac_d_q, mac_d_d;
  logic        in_ready_q, in_ready_d;
  logic [3:0]  mac_ena_q, mac_ena_d;
  logic        out_valid_q, out_valid_d;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    flg_d     = flg_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    lat_cnt_d = lat_cnt_q;
    mac_a_d   = mac_a_q;
    mac_b_d   = mac_b_q;
    mac_d_d   = mac_d_q;
    case (state_q)
      ACCEPT: begin
        if (in_valid && in_ready_q) begin
          mac_a_d = in_a;
          mac_b_d = in_b;
          mac_d_d = acc_q;
          last_d  = in_last;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        lat_cnt_d = LAT_INIT;
        state_d   = WAIT;
      end
      WAIT: begin
        lat_cnt_d = lat_cnt_q - 3'd1;
        if (lat_cnt_q <= 3'd1) begin
          // MAC result is valid only on this cycle; bits above the DLFloat16 field mean precision loss
          lat_cnt_d = '0;
          acc_d     = mac_c[15:0];
          flg_d     = flg_q | mac_flags | ((|mac_c[19:16]) ? 5'b01000 : 5'b00000);
          cnt_d     = cnt_q + 8'd1;
          if (last_q || cnt_d == MAX_CNT) state_d = DONE;
`ifdef DLFLOAT_SEQ_OVF_STOP_EN
          else if (mac_flags[2]) state_d = DRAIN;
`endif
          else state_d = ACCEPT;
        end
      end
      DONE: begin
        if (out_ready) begin
          acc_d   = '0;
          flg_d   = '0;
          cnt_d   = '0;
          last_d  = 1'b0;
          state_d = ACCEPT;
        end
      end
`ifdef DLFLOAT_SEQ_OVF_STOP_EN
      DRAIN: begin
        if (in_valid && in_ready_q && in_last) state_d = DONE;
      end
`endif
      default: state_d = ACCEPT;
    endcase

`ifdef DLFLOAT_SEQ_OVF_STOP_EN
    in_ready_d = (state_d == ACCEPT) || (state_d == DRAIN);
`else
    in_ready_d = (state_d == ACCEPT);
`endif
    mac_ena_d   = (state_d == ISSUE) ? 4'b1001 : 4'b0000;
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCEPT;
      acc_q       <= '0;
      flg_q       <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      lat_cnt_q   <= '0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_d_q     <= '0;
      in_ready_q  <= 1'b0;
      mac_ena_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      flg_q       <= flg_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      lat_cnt_q   <= lat_cnt_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      mac_d_q     <= mac_d_d;
      in_ready_q  <= in_ready_d;
      mac_ena_q   <= mac_ena_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign mac_a      = mac_a_q;
  assign mac_b      = mac_b_q;
  assign mac_d      = mac_d_q;
  assign mac_ena    = mac_ena_q;
  assign out_valid  = out_valid_q;
  assign out_result = acc_q;
  assign out_flags  = flg_q;
  assign out_count  = cnt_q;

endmodule

// File: tb/tb_dlfloat16_dot_seq.sv
// tb/tb_dlfloat16_dot_seq.sv - scoreboard bench for dlfloat16_dot_seq with a latency-accurate MAC stub
module tb_dlfloat16_dot_seq;
  localparam int MAX_TERMS = 3;
  localparam int MAC_LAT   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last;
  logic [15:0] in_a, in_b;
  logic [15:0] mac_a, mac_b, mac_d;
  logic [3:0]  mac_ena;
  logic [19:0] mac_c;
  logic [4:0]  mac_flags;
  logic        out_valid, out_ready;
  logic [15:0] out_result;
  logic [4:0]  out_flags;
  logic [7:0]  out_count;

  always #5 clk = ~clk;

  dlfloat16_dot_seq #(.MAX_TERMS(MAX_TERMS), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mac_a(mac_a), .mac_b(mac_b), .mac_d(mac_d), .mac_ena(mac_ena),
    .mac_c(mac_c), .mac_flags(mac_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .out_count(out_count)
  );

  // Stub arithmetic: b with top nibble F is a control operand (product = a, flags/extra bits from b)
  function automatic logic [15:0] stub_p(input logic [15:0] a, input logic [15:0] b);
    if (b[15:12] == 4'hF) return a;
    else if (a == 16'h3E00) return b;
    else if (b == 16'h3E00) return a;
    else return a ^ b;
  endfunction

  function automatic logic [19:0] stub_c(input logic [15:0] a, input logic [15:0] b, input logic [15:0] d);
    logic [15:0] p, s;
    logic [3:0]  hi;
    p  = stub_p(a, b);
    if (d == 16'h0000) s = p;
    else if (d == 16'h3E00 && p == 16'h3E00) s = 16'h4000;
    else s = d + p;
    hi = (b[15:12] == 4'hF && b[8]) ? 4'h1 : 4'h0;
    return {hi, s};
  endfunction

  function automatic logic [4:0] stub_f(input logic [15:0] b);
    return (b[15:12] == 4'hF) ? b[4:0] : 5'b00000;
  endfunction

  logic [MAC_LAT-1:0] st_v;
  logic [19:0]        st_c [MAC_LAT];
  logic [4:0]         st_f [MAC_LAT];

  always @(posedge clk) begin
    if (rst) st_v <= '0;
    else begin
      st_v[0] <= (mac_ena == 4'b1001);
      st_c[0] <= stub_c(mac_a, mac_b, mac_d);
      st_f[0] <= stub_f(mac_b);
      for (int i = 1; i < MAC_LAT; i++) begin
        st_v[i] <= st_v[i-1];
        st_c[i] <= st_c[i-1];
        st_f[i] <= st_f[i-1];
      end
    end
  end

  // Outside the single valid cycle the stub drives poison so mistimed captures show up
  assign mac_c     = st_v[MAC_LAT-1] ? st_c[MAC_LAT-1] : 20'hFFFFF;
  assign mac_flags = st_v[MAC_LAT-1] ? st_f[MAC_LAT-1] : 5'b11111;

  typedef struct packed { logic [15:0] a; logic [15:0] b; logic [15:0] d; } iss_t;
  typedef struct packed { logic [15:0] res; logic [4:0] flg; logic [7:0] cnt; int lat; } res_t;

  iss_t issue_q[$];
  res_t res_q[$];
  int   n_vec = 0, n_err = 0;
  int   cyc = 0, close_cyc = 0;
  int   rdy_mode = 0;
  bit   mon_en = 1'b0;
  bit   prev_valid = 1'b0, prev_ready = 1'b0;
  logic [15:0] m_acc = '0;
  logic [4:0]  m_flg = '0;
  int   m_cnt = 0;
  bit   m_drain = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic push_res(input int lat);
    res_q.push_back({m_acc, m_flg, 8'(m_cnt), lat});
    close_cyc = cyc;
    m_acc = '0; m_flg = '0; m_cnt = 0;
  endtask

  task automatic model_accept(input logic [15:0] a, input logic [15:0] b, input logic last);
    logic [19:0] c;
    logic [4:0]  f;
    if (m_drain) begin
      if (last) begin
        push_res(1);
        m_drain = 1'b0;
      end
    end else begin
      issue_q.push_back({a, b, m_acc});
      c = stub_c(a, b, m_acc);
      f = stub_f(b);
      m_flg = m_flg | f | ((c[19:16] != 4'h0) ? 5'b01000 : 5'b00000);
      m_acc = c[15:0];
      m_cnt++;
      if (last || m_cnt == MAX_TERMS) push_res(1 + MAC_LAT);
`ifdef DLFLOAT_SEQ_OVF_STOP_EN
      else if (f[2]) m_drain = 1'b1;
`endif
    end
  endtask

  task automatic send_term(input logic [15:0] a, input logic [15:0] b, input logic last, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    t = 0;
    while (!in_ready && t < 300) begin @(posedge clk); #1; t++; end
    if (!in_ready) check_eq("accept_timeout", 32'(t), 0);
    else begin
      @(posedge clk); #1;
      model_accept(a, b, last);
    end
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && mon_en) begin
      if (mac_ena == 4'b1001) begin
        if (issue_q.size() == 0) check_eq("issue_unexpected", 1, 0);
        else begin
          iss_t e;
          e = issue_q.pop_front();
          check_eq("mac_a", 32'(mac_a), 32'(e.a));
          check_eq("mac_b", 32'(mac_b), 32'(e.b));
          check_eq("mac_d", 32'(mac_d), 32'(e.d));
          check_eq("in_ready_issue", 32'(in_ready), 0);
        end
      end else check_eq("mac_ena_idle", 32'(mac_ena), 0);
      if (prev_valid) check_eq("out_hold", 32'(out_valid), 32'(!prev_ready));
      if (out_valid) begin
        if (res_q.size() == 0) check_eq("out_unexpected", 1, 0);
        else begin
          if (!prev_valid) check_eq("out_latency", 32'(cyc - close_cyc), 32'(res_q[0].lat));
          check_eq("out_result", 32'(out_result), 32'(res_q[0].res));
          check_eq("out_flags", 32'(out_flags), 32'(res_q[0].flg));
          check_eq("out_count", 32'(out_count), 32'(res_q[0].cnt));
          check_eq("in_ready_done", 32'(in_ready), 0);
          if (out_ready) void'(res_q.pop_front());
        end
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b1; in_a = 16'h3E00; in_b = 16'h3E00; in_last = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_in_ready", 32'(in_ready), 0);
      check_eq("rst_mac_ena", 32'(mac_ena), 0);
      check_eq("rst_out_valid", 32'(out_valid), 0);
      check_eq("rst_mac_abd", 32'({mac_a, mac_b} | 32'(mac_d)), 0);
      check_eq("rst_out", 32'({out_result, out_flags, out_count}), 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("post_rst_in_ready", 32'(in_ready), 1);
    check_eq("post_rst_mac_ena", 32'(mac_ena), 0);
    check_eq("post_rst_out_valid", 32'(out_valid), 0);
    check_eq("post_rst_mac_a", 32'(mac_a), 0);
    check_eq("post_rst_out", 32'({out_result, out_flags, out_count}), 0);
    mon_en = 1'b1;

    send_term(16'h3E00, 16'h3E00, 1'b1, 0);
    send_term(16'h3E00, 16'h3E00, 1'b0, 0);
    send_term(16'h3E00, 16'h3E00, 1'b1, 0);

    rdy_mode = 2;
    fork
      begin
        for (int i = 1; i <= 5; i++) send_term(16'(i * 16'h0100), 16'h3E00, 1'b0, 0);
        send_term(16'h0600, 16'h3E00, 1'b1, 0);
      end
      begin
        for (int t = 0; t < 300 && !out_valid; t++) @(negedge clk);
        repeat (5) @(negedge clk);
        rdy_mode = 0;
      end
    join

    send_term(16'h3E00, 16'h3E00, 1'b0, 0);
    send_term(16'h3C00, 16'hF004, 1'b0, 1);
    send_term(16'h0200, 16'h3E00, 1'b1, 0);
    send_term(16'h3C00, 16'hF004, 1'b0, 0);
    send_term(16'h0200, 16'h3E00, 1'b0, 0);
    send_term(16'h0300, 16'h3E00, 1'b0, 2);
    send_term(16'h0400, 16'h3E00, 1'b1, 0);

    send_term(16'h3E00, 16'hF100, 1'b1, 0);

    rdy_mode = 1;
    for (int v = 0; v < 25; v++) begin
      int n;
      n = int'($urandom_range(1, 5));
      for (int t = 0; t < n; t++) begin
        logic [15:0] a, b;
        int sel;
        a = 16'($urandom);
        sel = int'($urandom_range(0, 9));
        case (sel)
          0:       b = 16'hF004;
          1:       b = 16'hF100;
          2:       b = 16'hF010;
          default: b = 16'($urandom_range(0, 32'hEFFF));
        endcase
        send_term(a, b, t == n - 1, int'($urandom_range(0, 2)));
      end
    end

    for (int t = 0; t < 3000 && (res_q.size() != 0 || issue_q.size() != 0); t++) @(negedge clk);
    check_eq("queues_drained", 32'(res_q.size() + issue_q.size()), 0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
